// File: rtl/spi_dac_pkg.sv
// Shared definitions for the dual-lane DAC SPI link: frame geometry, the per-channel
// command word and the receiver FSM state encoding.
package spi_dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 2;
    localparam int PD_W       = 2;
    localparam int DATA_W     = 12;
    localparam int CNT_W      = 5;

    typedef struct packed {
        logic [PD_W-1:0]   pd;
        logic [DATA_W-1:0] data;
    } dac_word_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_DONE
    } rx_state_e;

    function automatic dac_word_t frame_word(input logic [FRAME_BITS-1:0] frame);
        return dac_word_t'(frame[PD_W+DATA_W-1:0]);
    endfunction

    function automatic logic lead_nonzero(input logic [FRAME_BITS-1:0] frame);
        return |frame[FRAME_BITS-1 -: LEAD_BITS];
    endfunction

endpackage

// File: rtl/spi_dac_rx_if.sv
// Dual-lane DAC SPI bus: chip select, clock and one MOSI bit per channel.
interface spi_dac_rx_if;
    logic       spi_cs_ni;
    logic       spi_sck_i;
    logic [1:0] spi_mosi_i;

    modport master (output spi_cs_ni, output spi_sck_i, output spi_mosi_i);
    modport slave  (input  spi_cs_ni, input  spi_sck_i, input  spi_mosi_i);
endinterface

// File: rtl/spi_sync_edge.sv
// STAGES-deep synchronizer for an asynchronous level, with registered rise/fall strobes
// so edge events line up one cycle after the synchronized level changes.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_dac_rx.sv
// Dual-lane SPI receiver for DAC command frames. Define SPI_DAC_RX_LEAD_CHECK_EN to reject
// frames whose lead bits are nonzero; by default lead bits are ignored.
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_ni,
    spi_dac_rx_if.slave       spi,
    output logic [DATA_W-1:0] data0_o,
    output logic [PD_W-1:0]   pd0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [PD_W-1:0]   pd1_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              busy_o
);

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;

    // CS idles high so a released reset never looks like a frame start.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_ni(rst_ni), .async_i(spi.spi_cs_ni),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rst_ni(rst_ni), .async_i(spi.spi_sck_i),
        .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    logic [1:0][SYNC_STAGES-1:0] mosi_sync_q;
    logic [1:0]                  mosi;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            mosi_sync_q <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                mosi_sync_q[l] <= {mosi_sync_q[l][SYNC_STAGES-2:0], spi.spi_mosi_i[l]};
            end
        end
    end

    assign mosi = {mosi_sync_q[1][SYNC_STAGES-1], mosi_sync_q[0][SYNC_STAGES-1]};

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [FRAME_BITS-1:0] sh0_next, sh1_next;
    dac_word_t             word0_q, word0_d, word1_q, word1_d;
    logic                  ovr_q, ovr_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  last_edge;
    logic                  reject;

    assign sh0_next  = {sh0_q[FRAME_BITS-2:0], mosi[0]};
    assign sh1_next  = {sh1_q[FRAME_BITS-2:0], mosi[1]};
    assign last_edge = sck_fall && (cnt_q == CNT_W'(FRAME_BITS - 1));

`ifdef SPI_DAC_RX_LEAD_CHECK_EN
    assign reject = lead_nonzero(sh0_next) || lead_nonzero(sh1_next);
`else
    assign reject = 1'b0;
`endif

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        word0_d = word0_q;
        word1_d = word1_q;
        ovr_d   = ovr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                sh0_d = '0;
                sh1_d = '0;
                ovr_d = 1'b0;
                if (!cs_level) state_d = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (sck_fall) begin
                    sh0_d = sh0_next;
                    sh1_d = sh1_next;
                    cnt_d = cnt_q + 1'b1;
                end
                if (last_edge) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        word0_d = frame_word(sh0_next);
                        word1_d = frame_word(sh1_next);
                    end
                    state_d = cs_rise ? RX_IDLE : RX_DONE;
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    sh0_d   = '0;
                    sh1_d   = '0;
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            RX_DONE: begin
                if (cs_rise) begin
                    state_d = RX_IDLE;
                end else if (sck_fall && !ovr_q) begin
                    err_d = 1'b1;
                    ovr_d = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        busy_d = (state_d == RX_SHIFT);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            word0_q <= '0;
            word1_q <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            ovr_q   <= ovr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign data0_o = word0_q.data;
    assign pd0_o   = word0_q.pd;
    assign data1_o = word1_q.data;
    assign pd1_o   = word1_q.pd;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

    logic unused_ok;
    assign unused_ok = ^{cs_fall, sck_level, sck_rise, sh0_q[FRAME_BITS-1], sh1_q[FRAME_BITS-1]};

endmodule
